// File: rtl/wave_monitor_if.sv
// Sample-strobe and measurement-result bundle for wave_monitor.
// The master drives strobes, clear and acknowledge; the slave returns the latched measurement.
interface wave_monitor_if;
    logic        Enable;
    logic [11:0] Sample;
    logic        Clear;
    logic        Ack;
    logic        Valid;
    logic [19:0] Period;
    logic [11:0] PeakMax;
    logic [11:0] PeakMin;
    logic [11:0] PeakToPeak;
    logic        Overflow;
    logic        Timeout;

    modport master (
        output Enable, Sample, Clear, Ack,
        input  Valid, Period, PeakMax, PeakMin, PeakToPeak, Overflow, Timeout
    );

    modport slave (
        input  Enable, Sample, Clear, Ack,
        output Valid, Period, PeakMax, PeakMin, PeakToPeak, Overflow, Timeout
    );
endinterface

// File: rtl/wave_monitor.sv
// Measures the period and peak levels of a sampled waveform, using rising
// crossings of a midscale reference qualified by a hysteresis band.
module wave_monitor #(
    parameter int          MIDSCALE   = 2048,
    parameter int          HYST       = 16,
    parameter logic [19:0] MAX_PERIOD = 20'hFFFFF
) (
    input logic           Fg_CLK,
    input logic           RESET,
    wave_monitor_if.slave mon
);

    function automatic logic [11:0] clamp_code(input int v);
        if (v < 0)
            return 12'd0;
        else if (v > 4095)
            return 12'hFFF;
        else
            return 12'(v);
    endfunction

    function automatic logic [19:0] sat_inc(input logic [19:0] c);
        return (c == 20'hFFFFF) ? c : c + 20'd1;
    endfunction

    localparam logic [11:0] TH_LO = clamp_code(MIDSCALE - HYST);
    localparam logic [11:0] TH_HI = clamp_code(MIDSCALE + HYST);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t      state;
    logic [19:0] count;
    logic [11:0] run_max;
    logic [11:0] run_min;
    logic        low_seen;

    logic        vld_p1;
    logic [19:0] period_p1;
    logic [11:0] peak_max_p1;
    logic [11:0] peak_min_p1;
    logic [11:0] p2p_p1;
    logic        overflow_r;
    logic        timeout_r;

    logic        below_lo;
    logic        above_hi;
    logic [19:0] count_inc;

    assign below_lo  = (mon.Sample < TH_LO);
    assign above_hi  = (mon.Sample >= TH_HI);
    assign count_inc = sat_inc(count);

    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            state       <= IDLE;
            count       <= '0;
            run_max     <= '0;
            run_min     <= '0;
            low_seen    <= 1'b0;
            vld_p1      <= 1'b0;
            period_p1   <= '0;
            peak_max_p1 <= '0;
            peak_min_p1 <= '0;
            p2p_p1      <= '0;
            overflow_r  <= 1'b0;
            timeout_r   <= 1'b0;
        end else if (mon.Clear) begin
            // Soft clear drops any coincident strobe but keeps the last result.
            state      <= IDLE;
            count      <= '0;
            run_max    <= '0;
            run_min    <= '0;
            low_seen   <= 1'b0;
            vld_p1     <= 1'b0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            if (vld_p1 && mon.Ack)
                vld_p1 <= 1'b0;

            if (mon.Enable) begin
                case (state)
                    IDLE: begin
                        if (below_lo)
                            state <= ARM;
                    end
                    ARM: begin
                        if (above_hi) begin
                            state    <= MEASURE;
                            count    <= 20'd1;
                            run_max  <= mon.Sample;
                            run_min  <= mon.Sample;
                            low_seen <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (low_seen && above_hi) begin
                            // Completion: result stage boundary; an Ack in this
                            // cycle frees the result registers for the new value.
                            if (!vld_p1 || mon.Ack) begin
                                vld_p1      <= 1'b1;
                                period_p1   <= count;
                                peak_max_p1 <= run_max;
                                peak_min_p1 <= run_min;
                                p2p_p1      <= run_max - run_min;
                            end else begin
                                overflow_r <= 1'b1;
                            end
                            count    <= 20'd1;
                            run_max  <= mon.Sample;
                            run_min  <= mon.Sample;
                            low_seen <= 1'b0;
                        end else begin
                            count <= count_inc;
                            if (mon.Sample > run_max)
                                run_max <= mon.Sample;
                            if (mon.Sample < run_min)
                                run_min <= mon.Sample;
                            if (below_lo)
                                low_seen <= 1'b1;
                            if (count_inc >= MAX_PERIOD) begin
                                timeout_r <= 1'b1;
                                low_seen  <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mon.Valid      = vld_p1;
    assign mon.Period     = period_p1;
    assign mon.PeakMax    = peak_max_p1;
    assign mon.PeakMin    = peak_min_p1;
    assign mon.PeakToPeak = p2p_p1;
    assign mon.Overflow   = overflow_r;
    assign mon.Timeout    = timeout_r;

endmodule

// File: tb/tb_wave_monitor.sv
// Directed bench for wave_monitor: stimulus pushes hand-computed results to a
// scoreboard queue, and a monitor pops them whenever a new result is presented.
module tb_wave_monitor;

    localparam logic [19:0] MAX_P = 20'd100;

    logic Fg_CLK = 1'b0;
    logic RESET;
    logic auto_ack;

    wave_monitor_if mon();

    wave_monitor #(
        .MIDSCALE  (2048),
        .HYST      (16),
        .MAX_PERIOD(MAX_P)
    ) dut (
        .Fg_CLK(Fg_CLK),
        .RESET (RESET),
        .mon   (mon)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    typedef struct {
        int period;
        int pmax;
        int pmin;
        int p2p;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input int p, input int mx, input int mn);
        exp_t e;
        e.period = p;
        e.pmax   = mx;
        e.pmin   = mn;
        e.p2p    = mx - mn;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic en, input logic [11:0] s, input logic ack_in, input logic clr);
        @(posedge Fg_CLK);
        #1;
        mon.Enable = en;
        mon.Sample = s;
        mon.Clear  = clr;
        mon.Ack    = ack_in | (auto_ack & mon.Valid);
    endtask

    task automatic idle();
        step(1'b0, 12'd0, 1'b0, 1'b0);
    endtask

    // Optional gap cycles carry a crossing-level sample with Enable low.
    task automatic run_level(input logic [11:0] s, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, s, 1'b0, 1'b0);
            if (gap)
                step(1'b0, 12'hFFF, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge Fg_CLK);
        #1;
        RESET      = 1'b1;
        mon.Enable = 1'b0;
        mon.Clear  = 1'b0;
        mon.Ack    = 1'b0;
        repeat (n) @(posedge Fg_CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    int'(mon.Valid),      0);
        check({tag, "_period"},   int'(mon.Period),     0);
        check({tag, "_peakmax"},  int'(mon.PeakMax),    0);
        check({tag, "_peakmin"},  int'(mon.PeakMin),    0);
        check({tag, "_p2p"},      int'(mon.PeakToPeak), 0);
        check({tag, "_overflow"}, int'(mon.Overflow),   0);
        check({tag, "_timeout"},  int'(mon.Timeout),    0);
    endtask

    // Monitor: a result is new when Valid rises, or stays high after an accepted Ack.
    initial begin
        logic pv;
        logic pend;
        exp_t e;
        pv   = 1'b0;
        pend = 1'b0;
        forever begin
            @(negedge Fg_CLK);
            if (RESET) begin
                pv   = 1'b0;
                pend = 1'b0;
            end else begin
                if (mon.Valid && (!pv || pend)) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got Period=%0d PeakMax=%0d PeakMin=%0d, expected no result",
                                 mon.Period, mon.PeakMax, mon.PeakMin);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_period",  int'(mon.Period),     e.period);
                        check("sb_peakmax", int'(mon.PeakMax),    e.pmax);
                        check("sb_peakmin", int'(mon.PeakMin),    e.pmin);
                        check("sb_p2p",     int'(mon.PeakToPeak), e.p2p);
                    end
                end
                pv   = mon.Valid;
                pend = mon.Valid && mon.Ack;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of stimulus, expected completion within 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET      = 1'b1;
        auto_ack   = 1'b0;
        mon.Enable = 1'b0;
        mon.Sample = 12'd0;
        mon.Clear  = 1'b0;
        mon.Ack    = 1'b0;
        repeat (2) @(posedge Fg_CLK);
        #1;
        RESET = 1'b0;
        check_all_zero("por");

        // Square wave 8 low / 8 high, second period with Enable-low gaps.
        auto_ack = 1'b1;
        run_level(12'd1000, 8, 1'b0);
        run_level(12'd3000, 8, 1'b0);
        run_level(12'd1000, 8, 1'b0);
        push_exp(16, 3000, 1000);
        run_level(12'd3000, 8, 1'b1);
        run_level(12'd1000, 8, 1'b1);
        push_exp(16, 3000, 1000);
        run_level(12'd3000, 8, 1'b0);
        run_level(12'd1000, 8, 1'b0);

        // Reset mid-measurement with a pending result.
        auto_ack = 1'b0;
        push_exp(16, 3000, 1000);
        run_level(12'd3000, 4, 1'b0);
        idle();
        check("pre_reset_valid", int'(mon.Valid), 1);
        do_reset(2);
        check_all_zero("mid_reset");
        auto_ack = 1'b1;
        run_level(12'd3000, 4, 1'b0);
        run_level(12'd1000, 8, 1'b0);
        run_level(12'd3000, 4, 1'b0);
        run_level(12'd900, 6, 1'b0);
        push_exp(10, 3000, 900);
        run_level(12'd3000, 1, 1'b0);
        idle();
        idle();

        // Noise inside the hysteresis band while armed.
        step(1'b0, 12'd0, 1'b0, 1'b1);
        run_level(12'd1000, 1, 1'b0);
        for (int i = 0; i < 250; i++) begin
            step(1'b1, 12'd2040, 1'b0, 1'b0);
            step(1'b1, 12'd2056, 1'b0, 1'b0);
        end
        idle();
        check("noise_valid",   int'(mon.Valid),   0);
        check("noise_timeout", int'(mon.Timeout), 0);
        run_level(12'd3000, 4, 1'b0);
        run_level(12'd1000, 4, 1'b0);
        push_exp(8, 3000, 1000);
        run_level(12'd3000, 1, 1'b0);
        idle();
        idle();

        // Overflow: three completions without Ack.
        auto_ack = 1'b0;
        step(1'b0, 12'd0, 1'b0, 1'b1);
        run_level(12'd1000, 2, 1'b0);
        run_level(12'd3000, 8, 1'b0);
        run_level(12'd1000, 8, 1'b0);
        push_exp(16, 3000, 1000);
        run_level(12'd3500, 5, 1'b0);
        run_level(12'd500, 8, 1'b0);
        run_level(12'd3000, 8, 1'b0);
        run_level(12'd1000, 8, 1'b0);
        run_level(12'd3000, 1, 1'b0);
        idle();
        check("ovf_flag",    int'(mon.Overflow), 1);
        check("ovf_valid",   int'(mon.Valid),    1);
        check("ovf_period",  int'(mon.Period),   16);
        check("ovf_peakmax", int'(mon.PeakMax),  3000);
        check("ovf_peakmin", int'(mon.PeakMin),  1000);
        step(1'b0, 12'd0, 1'b1, 1'b0);
        idle();
        check("ack_valid_low",   int'(mon.Valid),    0);
        check("ovf_sticky",      int'(mon.Overflow), 1);

        // Clear with a coincident strobe, then a completion with coincident Ack.
        step(1'b1, 12'd1000, 1'b0, 1'b1);
        step(1'b1, 12'd3000, 1'b0, 1'b0);
        check("clr_overflow", int'(mon.Overflow), 0);
        check("clr_period",   int'(mon.Period),   16);
        check("clr_peakmax",  int'(mon.PeakMax),  3000);
        step(1'b1, 12'd3000, 1'b0, 1'b0);
        run_level(12'd1000, 1, 1'b0);
        run_level(12'd3000, 8, 1'b0);
        run_level(12'd1000, 8, 1'b0);
        push_exp(16, 3000, 1000);
        run_level(12'd3000, 4, 1'b0);
        run_level(12'd1200, 6, 1'b0);
        push_exp(10, 3000, 1200);
        step(1'b1, 12'd3000, 1'b1, 1'b0);
        idle();
        check("coinc_valid",    int'(mon.Valid),    1);
        check("coinc_overflow", int'(mon.Overflow), 0);
        check("coinc_period",   int'(mon.Period),   10);
        step(1'b0, 12'd0, 1'b1, 1'b0);
        idle();
        check("coinc_ack_low", int'(mon.Valid), 0);

        // Timeout after MAX_P strobes without a completion.
        step(1'b0, 12'd0, 1'b0, 1'b1);
        run_level(12'd1000, 1, 1'b0);
        run_level(12'd3000, 3, 1'b0);
        run_level(12'd1000, 3, 1'b0);
        push_exp(6, 3000, 1000);
        run_level(12'd3000, 1, 1'b0);
        run_level(12'd3000, 98, 1'b0);
        idle();
        check("tmo_before", int'(mon.Timeout), 0);
        run_level(12'd3000, 1, 1'b0);
        idle();
        check("tmo_flag",   int'(mon.Timeout), 1);
        check("tmo_valid",  int'(mon.Valid),   1);
        check("tmo_period", int'(mon.Period),  6);
        step(1'b0, 12'd0, 1'b1, 1'b0);
        idle();
        check("tmo_ack_low", int'(mon.Valid), 0);
        run_level(12'd1000, 1, 1'b0);
        run_level(12'd3000, 1, 1'b0);
        run_level(12'd1000, 2, 1'b0);
        push_exp(3, 3000, 1000);
        run_level(12'd3000, 1, 1'b0);
        idle();
        idle();
        check("tmo_sticky", int'(mon.Timeout), 1);

        repeat (4) idle();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
